wait_state_responder: RTL and testbench



---
 rtl/wait_state_responder.sv | 156 +++++++++++++++
 tb/tb_wait_state_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wait_state_responder.sv
// wait_state_responder
// Memory-backed responder for the req/ack bus. It inserts fixed or LFSR-driven
// wait states before each ack, so that master stall handling can be exercised.
// It also counts completed transfers and flags protocol and address errors.
//
// Ports:
//   clk    - clock, all logic on the rising edge
//   rst    - synchronous active-high reset
//   req    - request from master, held high until ack
//   cmd    - 1 = write, 0 = read
//   addr   - byte address (word aligned, below 2**(AW+2) to be in range)
//   wdata  - write data
//   ack    - one-cycle completion pulse
//   rdata  - read data, valid while ack is high, held until the next read
//   wr_cnt - completed writes (wraps)
//   rd_cnt - completed reads (wraps)
//   err    - sticky, an out-of-range access has been acked
//   viol   - sticky, req dropped while waiting for ack
module wait_state_responder #(
  parameter int          AW          = 4,
  parameter int          WAIT_CYCLES = 0,
  parameter bit          RAND_WAIT   = 1'b0,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,
  parameter logic [31:0] BAD_DATA    = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        cmd,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic [7:0]  wr_cnt,
  output logic [7:0]  rd_cnt,
  output logic        err,
  output logic        viol
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [7:0]  lfsr;
  logic        cmd_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [2**AW];

  logic          acc_cmd;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          acc_ok;
  logic [3:0]    wait_sel;
  logic          lfsr_fb;
  logic          go_resp;
  logic          mem_we;

  // A zero-wait transfer goes straight from IDLE to RESP on the accepting
  // edge, before the capture registers hold anything, so in IDLE the access
  // operands come directly from the bus; in WAIT they come from the captures.
  always_comb begin
    wait_sel = RAND_WAIT ? lfsr[3:0] : 4'(WAIT_CYCLES);
    lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    if (state == IDLE) begin
      acc_cmd   = cmd;
      acc_addr  = addr;
      acc_wdata = wdata;
    end else begin
      acc_cmd   = cmd_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
    acc_idx = acc_addr[AW+1:2];
    acc_ok  = ((acc_addr >> (AW + 2)) == 32'd0) && (acc_addr[1:0] == 2'b00);
    go_resp = 1'b0;
    case (state)
      IDLE:    go_resp = req && (wait_sel == 4'd0);
      WAIT:    go_resp = req && (cnt == 4'd1);
      default: go_resp = 1'b0;
    endcase
    mem_we = !rst && go_resp && acc_cmd && acc_ok;
  end

  // Storage has no reset so that its contents survive a reset; only in-range
  // writes entering RESP update it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  // Main FSM. ack is registered as "next state is RESP", which makes it equal
  // to state==RESP. The LFSR steps only when a request is accepted, so the
  // wait sequence depends on the transaction count, not on idle time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      lfsr    <= LFSR_SEED;
      ack     <= 1'b0;
      rdata   <= 32'd0;
      wr_cnt  <= 8'd0;
      rd_cnt  <= 8'd0;
      err     <= 1'b0;
      viol    <= 1'b0;
      cmd_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      ack <= go_resp;
      if (go_resp) begin
        if (acc_cmd) begin
          wr_cnt <= wr_cnt + 8'd1;
        end else begin
          rd_cnt <= rd_cnt + 8'd1;
          rdata  <= acc_ok ? mem[acc_idx] : BAD_DATA;
        end
        if (!acc_ok) begin
          err <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (req) begin
            cmd_q   <= cmd;
            addr_q  <= addr;
            wdata_q <= wdata;
            lfsr    <= {lfsr[6:0], lfsr_fb};
            if (wait_sel == 4'd0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= wait_sel;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
            viol  <= 1'b1;
          end else if (cnt == 4'd1) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wait_state_responder.sv
// tb_wait_state_responder
// Drives three responders side by side: fixed zero wait (index 0), fixed
// three waits (index 1) and LFSR waits (index 2). A transaction-level model
// (word array, counters, flags, LFSR sequence) predicts every response.
module tb_wait_state_responder;

  logic        clk = 1'b0;
  logic        rst_v   [3];
  logic        req_v   [3];
  logic        cmd_v   [3];
  logic [31:0] addr_v  [3];
  logic [31:0] wdata_v [3];
  logic        ack_v   [3];
  logic [31:0] rdata_v [3];
  logic [7:0]  wr_v    [3];
  logic [7:0]  rd_v    [3];
  logic        err_v   [3];
  logic        viol_v  [3];

  logic [31:0] mMem     [3][16];
  bit          mKnown   [3][16];
  logic [31:0] mRdata   [3];
  bit          mRdKnown [3];
  int          mWr      [3];
  int          mRd      [3];
  bit          mErr     [3];
  bit          mViol    [3];
  logic [7:0]  mLfsr    [3];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  wait_state_responder #(.AW(4), .WAIT_CYCLES(0), .RAND_WAIT(1'b0)) dut0 (
    .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .cmd(cmd_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .ack(ack_v[0]), .rdata(rdata_v[0]), .wr_cnt(wr_v[0]),
    .rd_cnt(rd_v[0]), .err(err_v[0]), .viol(viol_v[0]));

  wait_state_responder #(.AW(4), .WAIT_CYCLES(3), .RAND_WAIT(1'b0)) dut3 (
    .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .cmd(cmd_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .ack(ack_v[1]), .rdata(rdata_v[1]), .wr_cnt(wr_v[1]),
    .rd_cnt(rd_v[1]), .err(err_v[1]), .viol(viol_v[1]));

  wait_state_responder #(.AW(4), .WAIT_CYCLES(0), .RAND_WAIT(1'b1), .LFSR_SEED(8'hA5)) dutr (
    .clk(clk), .rst(rst_v[2]), .req(req_v[2]), .cmd(cmd_v[2]), .addr(addr_v[2]),
    .wdata(wdata_v[2]), .ack(ack_v[2]), .rdata(rdata_v[2]), .wr_cnt(wr_v[2]),
    .rd_cnt(rd_v[2]), .err(err_v[2]), .viol(viol_v[2]));

  // Responder configuration as seen by the model.
  function automatic int cfgWait(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  function automatic bit cfgRand(input int d);
    return d == 2;
  endfunction

  // Fibonacci LFSR with taps 8,6,5,4, shifting towards the MSB.
  function automatic logic [7:0] nextLfsr(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [31:0] randAddr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return 32'($urandom_range(0, 15) * 4);
    if (r == 8) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
    return $urandom | 32'h0000_0040;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset(input int d);
    mWr[d]      = 0;
    mRd[d]      = 0;
    mErr[d]     = 1'b0;
    mViol[d]    = 1'b0;
    mLfsr[d]    = 8'hA5;
    mRdata[d]   = 32'd0;
    mRdKnown[d] = 1'b1;
  endtask

  task automatic checkState(input int d, input string tag);
    checkOutput($sformatf("d%0d %s wr_cnt", d, tag), 32'(wr_v[d]), 32'(mWr[d] % 256));
    checkOutput($sformatf("d%0d %s rd_cnt", d, tag), 32'(rd_v[d]), 32'(mRd[d] % 256));
    checkOutput($sformatf("d%0d %s err", d, tag), 32'(err_v[d]), 32'(mErr[d]));
    checkOutput($sformatf("d%0d %s viol", d, tag), 32'(viol_v[d]), 32'(mViol[d]));
    if (mRdKnown[d]) begin
      checkOutput($sformatf("d%0d %s rdata", d, tag), rdata_v[d], mRdata[d]);
    end
  endtask

  // Entered at a falling edge with the responder idle. Presents one request,
  // scrambles the bus after acceptance, and checks latency and results.
  // dropAfter>0 withdraws req during the wait instead of completing.
  task automatic applyStimulus(input int d, input bit wr, input logic [31:0] a,
                               input logic [31:0] data, input int dropAfter, input bit keepReq);
    int w;
    int lat;
    int idx;
    bit ok;
    logic [7:0] cur;
    req_v[d]   = 1'b1;
    cmd_v[d]   = wr;
    addr_v[d]  = a;
    wdata_v[d] = data;
    cur = mLfsr[d];
    w = cfgRand(d) ? int'(cur[3:0]) : cfgWait(d);
    mLfsr[d] = nextLfsr(cur);
    @(negedge clk);
    cmd_v[d]   = 1'($urandom);
    addr_v[d]  = $urandom;
    wdata_v[d] = $urandom;
    if (dropAfter > 0) begin
      for (int k = 1; k < dropAfter; k++) begin
        checkOutput($sformatf("d%0d ack during wait", d), 32'(ack_v[d]), 32'd0);
        @(negedge clk);
      end
      checkOutput($sformatf("d%0d ack before drop", d), 32'(ack_v[d]), 32'd0);
      req_v[d] = 1'b0;
      mViol[d] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        checkOutput($sformatf("d%0d ack after drop", d), 32'(ack_v[d]), 32'd0);
      end
      checkState(d, "after drop");
      return;
    end
    lat = 1;
    while (ack_v[d] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (ack_v[d] !== 1'b1) begin
      checkOutput($sformatf("d%0d ack timeout", d), 32'(ack_v[d]), 32'd1);
      req_v[d] = 1'b0;
      @(negedge clk);
      return;
    end
    checkOutput($sformatf("d%0d latency", d), 32'(lat), 32'(w + 1));
    ok  = (a < 64) && (a % 4 == 0);
    idx = int'(a / 4) % 16;
    if (wr) begin
      mWr[d]++;
      if (ok) begin
        mMem[d][idx]   = data;
        mKnown[d][idx] = 1'b1;
      end
    end else begin
      mRd[d]++;
      if (ok) begin
        mRdata[d]   = mMem[d][idx];
        mRdKnown[d] = mKnown[d][idx];
      end else begin
        mRdata[d]   = 32'hDEADBEEF;
        mRdKnown[d] = 1'b1;
      end
    end
    if (!ok) mErr[d] = 1'b1;
    checkState(d, wr ? "write" : "read");
    req_v[d] = keepReq;
    @(negedge clk);
    checkOutput($sformatf("d%0d ack single cycle", d), 32'(ack_v[d]), 32'd0);
  endtask

  // Starts a request and hits reset while it is still waiting.
  task automatic abortByReset(input int d, input bit wr, input logic [31:0] a, input logic [31:0] data);
    req_v[d]   = 1'b1;
    cmd_v[d]   = wr;
    addr_v[d]  = a;
    wdata_v[d] = data;
    @(negedge clk);
    checkOutput($sformatf("d%0d ack before reset", d), 32'(ack_v[d]), 32'd0);
    rst_v[d] = 1'b1;
    req_v[d] = 1'b0;
    @(negedge clk);
    rst_v[d] = 1'b0;
    modelReset(d);
    checkOutput($sformatf("d%0d ack after reset", d), 32'(ack_v[d]), 32'd0);
    checkState(d, "after reset");
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_v[d]   = 1'b1;
      req_v[d]   = 1'b0;
      cmd_v[d]   = 1'b0;
      addr_v[d]  = 32'd0;
      wdata_v[d] = 32'd0;
      for (int i = 0; i < 16; i++) begin
        mMem[d][i]   = 32'd0;
        mKnown[d][i] = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      rst_v[d] = 1'b0;
      modelReset(d);
      checkOutput($sformatf("d%0d reset ack", d), 32'(ack_v[d]), 32'd0);
      checkState(d, "reset");
    end

    $display("[TB] zero-wait write/read");
    applyStimulus(0, 1'b1, 32'd8, 32'h1234_5678, 0, 1'b0);
    applyStimulus(0, 1'b0, 32'd8, 32'h0, 0, 1'b0);
    checkOutput("d0 rdata after first read", rdata_v[0], 32'h1234_5678);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 1'($urandom), randAddr(), $urandom, 0, 1'($urandom));
    end
    req_v[0] = 1'b0;

    $display("[TB] three-wait responder");
    applyStimulus(1, 1'b1, 32'd4, 32'hCAFE_F00D, 0, 1'b0);
    applyStimulus(1, 1'b1, 32'd8, 32'h0BAD_F00D, 0, 1'b0);
    applyStimulus(1, 1'b0, 32'd8, 32'h0, 0, 1'b0);
    applyStimulus(1, 1'b0, 32'h100, 32'h0, 0, 1'b0);
    checkOutput("d1 out-of-range read data", rdata_v[1], 32'hDEADBEEF);
    applyStimulus(1, 1'b1, 32'd6, 32'h5555_5555, 0, 1'b0);
    applyStimulus(1, 1'b0, 32'd4, 32'h0, 0, 1'b0);
    checkOutput("d1 misaligned write discarded", rdata_v[1], 32'hCAFE_F00D);
    applyStimulus(1, 1'b0, 32'd8, 32'h0, 1, 1'b0);
    applyStimulus(1, 1'b0, 32'd8, 32'h0, 0, 1'b0);
    abortByReset(1, 1'b1, 32'd4, 32'h1111_1111);
    applyStimulus(1, 1'b0, 32'd4, 32'h0, 0, 1'b0);
    checkOutput("d1 memory survives reset", rdata_v[1], 32'hCAFE_F00D);

    $display("[TB] random-wait back-to-back writes");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(2, 1'b1, randAddr(), $urandom, 0, i != 299);
    end
    req_v[2] = 1'b0;
    checkOutput("d2 wr_cnt after 300 writes", 32'(wr_v[2]), 32'd44);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(2, 1'b0, 32'(i * 4), 32'h0, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
